pipelined_datapath: RTL and testbench

//   Parametrised successor to the 4-register datapath: NUM_REGS x DATA_W register file, 2-stage

---
 rtl/datapath_pkg.sv | 26 ++
 rtl/seq_multiplier.sv | 54 +++++
 rtl/pipelined_datapath.sv | 205 ++++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: ALU opcodes, issue FSM states and
// flag bit positions.
package datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_OR   = 3'b100,
        ALU_SHL1 = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_MUL  = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } dp_state_e;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned NUM_FLAGS  = 3;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W steps after start.
// product is the accumulator including the current step, so it is final while done is high.
module seq_multiplier #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    always_comb begin
        product = acc_q + (mplier_q[0] ? mcand_q : '0);
        done    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
        busy    = busy_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{DATA_W{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage register-file datapath (read/execute -> writeback) with EX->read bypass,
// valid/ready issue and an iterative MUL that stalls issue while it runs.
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instValid,
    output logic              instReady,
    input  logic [ADDR_W-1:0] srcReg1Addr,
    input  logic [ADDR_W-1:0] srcReg2Addr,
    input  logic [ADDR_W-1:0] destRegAddr,
    input  logic [2:0]        aluOp,
    input  logic              regWrite,
    output logic [DATA_W-1:0] aluResult,
    output logic              resultValid,
    output logic              flagZero,
    output logic              flagCarry,
    output logic              flagOvf,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData
);

    logic [DATA_W-1:0]    rf_q [NUM_REGS];

    logic                 ex_valid_q;
    logic                 ex_write_q;
    logic [ADDR_W-1:0]    ex_dest_q;
    logic [DATA_W-1:0]    ex_result_q;
    logic [NUM_FLAGS-1:0] ex_flags_q;

    dp_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    mul_dest_q;
    logic                 mul_write_q;

    logic [DATA_W-1:0]    op_a, op_b;
    logic [DATA_W:0]      sum_ext, diff_ext;
    logic [DATA_W-1:0]    alu_res;
    logic                 alu_carry, alu_ovf;

    logic                 mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0]  mul_product;

    logic                 load_ex;
    logic [DATA_W-1:0]    new_result;
    logic [NUM_FLAGS-1:0] new_flags;
    logic [ADDR_W-1:0]    new_dest;
    logic                 new_write;

    // Writes to a hard-wired zero register are dropped before they reach EX, which also
    // keeps them off the bypass path.
    function automatic logic dest_writable(input logic [ADDR_W-1:0] dest);
        return !(ZERO_REG && (dest == '0));
    endfunction

    always_comb begin
        op_a = rf_q[srcReg1Addr];
        if (ex_valid_q && ex_write_q && (ex_dest_q == srcReg1Addr)) begin
            op_a = ex_result_q;
        end
        if (ZERO_REG && (srcReg1Addr == '0)) begin
            op_a = '0;
        end
        op_b = rf_q[srcReg2Addr];
        if (ex_valid_q && ex_write_q && (ex_dest_q == srcReg2Addr)) begin
            op_b = ex_result_q;
        end
        if (ZERO_REG && (srcReg2Addr == '0)) begin
            op_b = '0;
        end
    end

    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    // Top bit of the extended difference is the unsigned borrow.
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_op_e'(aluOp))
            ALU_ADD: begin
                alu_res   = sum_ext[DATA_W-1:0];
                alu_carry = sum_ext[DATA_W];
                alu_ovf   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res   = diff_ext[DATA_W-1:0];
                alu_carry = diff_ext[DATA_W];
                alu_ovf   = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            ALU_AND:  alu_res = op_a & op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_SHL1: alu_res = {op_a[DATA_W-2:0], 1'b0};
            ALU_SLT:  alu_res = DATA_W'(op_a < op_b);
            ALU_MUL:  alu_res = '0;
            default:  alu_res = '0;
        endcase
    end

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d               = state_q;
        instReady             = 1'b0;
        mul_start             = 1'b0;
        load_ex               = 1'b0;
        new_result            = alu_res;
        new_flags             = '0;
        new_flags[FLAG_CARRY] = alu_carry;
        new_flags[FLAG_OVF]   = alu_ovf;
        new_dest              = destRegAddr;
        new_write             = regWrite && dest_writable(destRegAddr);
        unique case (state_q)
            ST_IDLE: begin
                instReady = 1'b1;
                if (instValid) begin
                    if (aluOp == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_BUSY;
                    end else begin
                        load_ex = 1'b1;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (mul_busy && mul_done) begin
                    state_d               = ST_IDLE;
                    load_ex               = 1'b1;
                    new_result            = mul_product[DATA_W-1:0];
                    new_flags[FLAG_CARRY] = |mul_product[2*DATA_W-1:DATA_W];
                    new_flags[FLAG_OVF]   = 1'b0;
                    new_dest              = mul_dest_q;
                    new_write             = mul_write_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        new_flags[FLAG_ZERO] = (new_result == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ex_valid_q  <= 1'b0;
            ex_write_q  <= 1'b0;
            ex_dest_q   <= '0;
            ex_result_q <= '0;
            ex_flags_q  <= '0;
            mul_dest_q  <= '0;
            mul_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= load_ex;
            // Result and flags hold between instructions; only resultValid drops.
            if (load_ex) begin
                ex_result_q <= new_result;
                ex_flags_q  <= new_flags;
                ex_dest_q   <= new_dest;
                ex_write_q  <= new_write;
            end
            if (mul_start) begin
                mul_dest_q  <= destRegAddr;
                mul_write_q <= regWrite && dest_writable(destRegAddr);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= DATA_W'(i);
            end
        end else if (ex_valid_q && ex_write_q) begin
            rf_q[ex_dest_q] <= ex_result_q;
        end
    end

    assign aluResult   = ex_result_q;
    assign resultValid = ex_valid_q;
    assign flagZero    = ex_flags_q[FLAG_ZERO];
    assign flagCarry   = ex_flags_q[FLAG_CARRY];
    assign flagOvf     = ex_flags_q[FLAG_OVF];
    assign dbgData     = rf_q[dbgAddr];

endmodule

// File: tb/tb_pipelined_datapath.sv
// Randomized bench for pipelined_datapath: two instances (ZERO_REG=0 and 1) share stimulus
// and are checked against an instruction-level sequential model with a completion timeline.
module tb_pipelined_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_valid;
    logic [1:0] src1, src2, dst, dbg_addr;
    logic [2:0] alu_op;
    logic       reg_write;

    logic       rdy [2];
    logic       rv  [2];
    logic [7:0] res [2];
    logic       fz  [2];
    logic       fc  [2];
    logic       fv  [2];
    logic [7:0] dbg [2];

    always #5 clk = ~clk;

    pipelined_datapath #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .reset(reset), .instValid(inst_valid), .instReady(rdy[0]),
        .srcReg1Addr(src1), .srcReg2Addr(src2), .destRegAddr(dst), .aluOp(alu_op),
        .regWrite(reg_write), .aluResult(res[0]), .resultValid(rv[0]), .flagZero(fz[0]),
        .flagCarry(fc[0]), .flagOvf(fv[0]), .dbgAddr(dbg_addr), .dbgData(dbg[0])
    );

    pipelined_datapath #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .reset(reset), .instValid(inst_valid), .instReady(rdy[1]),
        .srcReg1Addr(src1), .srcReg2Addr(src2), .destRegAddr(dst), .aluOp(alu_op),
        .regWrite(reg_write), .aluResult(res[1]), .resultValid(rv[1]), .flagZero(fz[1]),
        .flagCarry(fc[1]), .flagOvf(fv[1]), .dbgAddr(dbg_addr), .dbgData(dbg[1])
    );

    typedef struct {
        int       due;
        int       res;
        bit       fz;
        bit       fc;
        bit       fv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last [2];
    int   m_rf [2][4];
    int   t;
    int   busy_until;
    bit   accepted;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, t);
    endtask

    task automatic model_compute(input int op, input int a, input int b, output exp_t e);
        int sa, sb, r;
        sa   = (a > 127) ? a - 256 : a;
        sb   = (b > 127) ? b - 256 : b;
        e.fc = 1'b0;
        e.fv = 1'b0;
        case (op)
            0: begin r = a + b; e.fc = (r > 255); e.fv = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = a - b; e.fc = (a < b);   e.fv = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a ^ b;
            4: r = a | b;
            5: r = a * 2;
            6: r = (a < b) ? 1 : 0;
            default: begin r = a * b; e.fc = (r > 255); end
        endcase
        e.res = r & 255;
        e.fz  = (e.res == 0);
        e.due = 0;
    endtask

    // Instructions execute in program order on the model's architectural registers;
    // only the completion time depends on the pipeline.
    task automatic model_issue();
        exp_t e;
        int   a, b;
        for (int z = 0; z < 2; z++) begin
            a = (z == 1 && src1 == 0) ? 0 : m_rf[z][src1];
            b = (z == 1 && src2 == 0) ? 0 : m_rf[z][src2];
            model_compute(int'(alu_op), a, b, e);
            e.due = (alu_op == 3'd7) ? t + 9 : t + 1;
            if (reg_write && !(z == 1 && dst == 0)) m_rf[z][dst] = e.res;
            if (z == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (alu_op == 3'd7) busy_until = t + 8;
    endtask

    task automatic check_outputs();
        bit ev;
        for (int z = 0; z < 2; z++) begin
            ev = 1'b0;
            if (z == 0 && q0.size() > 0 && q0[0].due == t) begin last[0] = q0.pop_front(); ev = 1; end
            if (z == 1 && q1.size() > 0 && q1[0].due == t) begin last[1] = q1.pop_front(); ev = 1; end
            check_eq($sformatf("d%0d.instReady", z), 32'(rdy[z]), 32'(t > busy_until));
            check_eq($sformatf("d%0d.resultValid", z), 32'(rv[z]), 32'(ev));
            check_eq($sformatf("d%0d.aluResult", z), 32'(res[z]), 32'(last[z].res));
            check_eq($sformatf("d%0d.flagZero", z), 32'(fz[z]), 32'(last[z].fz));
            check_eq($sformatf("d%0d.flagCarry", z), 32'(fc[z]), 32'(last[z].fc));
            check_eq($sformatf("d%0d.flagOvf", z), 32'(fv[z]), 32'(last[z].fv));
        end
    endtask

    task automatic tick();
        accepted = inst_valid && (t > busy_until);
        if (accepted) model_issue();
        @(negedge clk);
        t++;
        check_outputs();
    endtask

    task automatic issue(input int op, input int s1, input int s2, input int d, input bit w);
        int guard;
        inst_valid = 1'b1;
        alu_op     = 3'(op);
        src1       = 2'(s1);
        src2       = 2'(s2);
        dst        = 2'(d);
        reg_write  = w;
        guard      = 0;
        do begin
            tick();
            guard++;
        end while (!accepted && guard < 32);
        if (!accepted) check_eq("issue_timeout", 32'(guard), 32'(0));
    endtask

    task automatic idle(input int n);
        inst_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_regs();
        idle(2);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            for (int z = 0; z < 2; z++) begin
                check_eq($sformatf("d%0d.R%0d", z, i), 32'(dbg[z]), 32'(m_rf[z][i]));
            end
        end
    endtask

    task automatic peek(input int z, input int i, input int exp, input string tag);
        dbg_addr = 2'(i);
        #1;
        check_eq(tag, 32'(dbg[z]), 32'(exp));
    endtask

    task automatic do_reset();
        inst_valid = 1'b0;
        reset      = 1'b0;
        q0.delete();
        q1.delete();
        busy_until = -1;
        for (int z = 0; z < 2; z++) begin
            last[z] = '{due: 0, res: 0, fz: 1'b0, fc: 1'b0, fv: 1'b0};
            for (int i = 0; i < 4; i++) m_rf[z][i] = (z == 1 && i == 0) ? 0 : i;
        end
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        t     = 0;
        check_outputs();
    endtask

    initial begin
        int busy_cnt;
        reset      = 1'b1;
        inst_valid = 1'b0;
        alu_op     = '0;
        src1       = '0;
        src2       = '0;
        dst        = '0;
        reg_write  = 1'b0;
        dbg_addr   = '0;
        t          = 0;
        busy_until = -1;
        @(negedge clk);

        // Back-to-back issue with bypass chain: results 3, 2, 1.
        do_reset();
        issue(0, 1, 2, 0, 1);
        issue(2, 2, 3, 1, 1);
        issue(3, 2, 0, 3, 1);
        check_regs();
        peek(0, 0, 3, "b2b.R0");
        peek(0, 1, 2, "b2b.R1");
        peek(0, 3, 1, "b2b.R3");

        // EX->read bypass on the very next instruction.
        do_reset();
        issue(0, 1, 2, 0, 1);
        issue(0, 0, 0, 1, 1);
        check_regs();
        peek(0, 1, 6, "bypass.R1");

        // SUB borrow, then build 0x7F and add 1 for signed overflow.
        do_reset();
        issue(1, 1, 2, 0, 1);
        issue(2, 1, 1, 3, 1);
        for (int i = 0; i < 7; i++) issue(5, 3, 0, 3, 1);
        issue(3, 0, 3, 0, 1);
        issue(0, 0, 1, 2, 1);
        check_regs();
        peek(0, 2, 8'h80, "ovf.R2");

        // MUL stalls issue for DATA_W cycles; the next instruction is held and then taken.
        do_reset();
        issue(7, 3, 3, 2, 1);
        inst_valid = 1'b0;
        busy_cnt   = 1;
        while (!rdy[0] && busy_cnt < 20) begin
            tick();
            if (!rdy[0]) busy_cnt++;
        end
        check_eq("mul.busy_cycles", 32'(busy_cnt), 32'(8));
        issue(7, 3, 3, 2, 1);
        issue(0, 2, 1, 0, 1);
        check_regs();
        peek(0, 2, 9, "mul.R2");

        // Reset part-way through a MUL aborts it.
        do_reset();
        issue(7, 3, 3, 2, 1);
        idle(2);
        do_reset();
        idle(12);
        check_regs();
        peek(0, 2, 2, "abort.R2");

        // Hard-wired zero register on the ZERO_REG instance.
        do_reset();
        issue(0, 3, 3, 0, 1);
        idle(1);
        issue(0, 0, 3, 1, 1);
        check_regs();
        peek(1, 0, 0, "zr.R0");
        peek(1, 1, 3, "zr.R1");

        // Random traffic with held requests while busy.
        do_reset();
        inst_valid = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!inst_valid || accepted) begin
                inst_valid = ($urandom_range(0, 3) != 0);
                alu_op     = 3'($urandom_range(0, 7));
                src1       = 2'($urandom_range(0, 3));
                src2       = 2'($urandom_range(0, 3));
                dst        = 2'($urandom_range(0, 3));
                reg_write  = ($urandom_range(0, 4) != 0);
            end
            tick();
            if (n % 100 == 99) begin
                check_regs();
                accepted = 1'b1;
            end
        end
        idle(12);
        check_regs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
